// File: rtl/addsub_pkg.sv
// Shared FSM encodings and width-derived constants for the sequential adder/subtractor.
package addsub_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Returned 64 bits wide; callers size-cast to their operand width.
  function automatic logic [63:0] maxpos(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] maxneg(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/addsub_if.sv
// Operand/result handshake bundle between operand entry, the adder and the display converter.
interface addsub_if #(
  parameter int WIDTH = 10
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             acc_mode;
  logic             clr_acc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             overflow;
  logic             carry_out;
  logic [WIDTH-1:0] acc;

  modport master (
    output in_valid, a, b, sub, acc_mode, clr_acc, out_ready,
    input  in_ready, out_valid, sum, overflow, carry_out, acc
  );

  modport slave (
    input  in_valid, a, b, sub, acc_mode, clr_acc, out_ready,
    output in_ready, out_valid, sum, overflow, carry_out, acc
  );
endinterface

// File: rtl/addsub_slice.sv
// Combinational CHUNK-bit ripple of fa cells; also exposes the carry into its top bit
// so the caller can derive signed overflow on the last chunk.
module addsub_slice #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             cmsb
);
  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    fa u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
  end

  assign cout = c[CHUNK];
  assign cmsb = c[CHUNK-1];
endmodule

// File: rtl/fa.sv
// Single-bit full adder cell.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle add/sub, CHUNK bits per clock through one slice; result NCHUNK cycles after accept.
// Accepts only in IDLE, holds the result in DONE until out_ready; no input buffering.
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int CHUNK  = 2,
  parameter bit SAT_EN = 1'b0
) (
  input logic     clk,
  input logic     rst_n,
  addsub_if.slave io
);
  localparam int               NCH    = nchunk(WIDTH, CHUNK);
  localparam int               KW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [KW-1:0]    KLAST  = KW'(NCH - 1);
  localparam logic [WIDTH-1:0] MAXPOS = WIDTH'(maxpos(WIDTH));
  localparam logic [WIDTH-1:0] MAXNEG = WIDTH'(maxneg(WIDTH));

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("addsub_seq: WIDTH must be a multiple of CHUNK");
  end

  logic [1:0]       state;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] bn;
  logic             carry;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] sat_val;
  logic [CHUNK-1:0] s_chunk;
  logic             c_out;
  logic             c_msb;
  logic             ovf_raw;

  addsub_slice #(.CHUNK(CHUNK)) u_slice (
    .a    (opa[k*CHUNK +: CHUNK]),
    .b    (bn[k*CHUNK +: CHUNK]),
    .cin  (carry),
    .s    (s_chunk),
    .cout (c_out),
    .cmsb (c_msb)
  );

  always_comb begin
    raw = res;
    raw[k*CHUNK +: CHUNK] = s_chunk;
  end

  // Only meaningful on the last chunk, where c_msb is the carry into bit WIDTH-1.
  assign ovf_raw = c_msb ^ c_out;
  assign sat_val = opa[WIDTH-1] ? MAXNEG : MAXPOS;

  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      k            <= '0;
      opa          <= '0;
      bn           <= '0;
      carry        <= 1'b0;
      res          <= '0;
      io.sum       <= '0;
      io.overflow  <= 1'b0;
      io.carry_out <= 1'b0;
      io.acc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io.clr_acc) io.acc <= '0;
          if (io.in_valid) begin
            opa   <= io.acc_mode ? (io.clr_acc ? '0 : io.acc) : io.a;
            bn    <= io.b ^ {WIDTH{io.sub}};
            carry <= io.sub;
            k     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          res   <= raw;
          carry <= c_out;
          if (k == KLAST) begin
            io.sum       <= (SAT_EN && ovf_raw) ? sat_val : raw;
            io.overflow  <= ovf_raw;
            io.carry_out <= c_out;
            state        <= DONE;
          end else begin
            k <= k + KW'(1);
          end
        end
        DONE: begin
          if (io.out_ready) begin
            io.acc <= io.sum;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_addsub_seq.sv
`timescale 1ns/1ps
// Drives five adder configurations in lockstep and checks them against an integer reference model.
module tb_addsub_seq;
  localparam int W    = 10;
  localparam int NI   = 5;
  localparam int NOPS = 4000;

  function automatic int ch_of(input int i);
    case (i)
      0, 1:    return 2;
      2:       return 1;
      3:       return 5;
      default: return 10;
    endcase
  endfunction

  function automatic bit sat_of(input int i);
    return (i == 1) || (i == 3);
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic         sub = 1'b0;
  logic         acc_mode = 1'b0;
  logic         clr_acc = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  logic [NI-1:0] in_ready_v, out_valid_v, ovf_v, co_v;
  logic [W-1:0]  sum_v [NI];
  logic [W-1:0]  acc_v [NI];

  int n_chk = 0;
  int n_fail = 0;

  for (genvar i = 0; i < NI; i++) begin : g_dut
    addsub_if #(.WIDTH(W)) bus ();
    assign bus.in_valid  = in_valid;
    assign bus.a         = a;
    assign bus.b         = b;
    assign bus.sub       = sub;
    assign bus.acc_mode  = acc_mode;
    assign bus.clr_acc   = clr_acc;
    assign bus.out_ready = out_ready;
    assign in_ready_v[i]  = bus.in_ready;
    assign out_valid_v[i] = bus.out_valid;
    assign ovf_v[i]       = bus.overflow;
    assign co_v[i]        = bus.carry_out;
    assign sum_v[i]       = bus.sum;
    assign acc_v[i]       = bus.acc;

    addsub_seq #(.WIDTH(W), .CHUNK(ch_of(i)), .SAT_EN(sat_of(i))) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (bus)
    );
  end

  // Signed-integer view of the operation.
  function automatic void model(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic os,
                                input bit sat, output logic [W-1:0] s, output logic ov,
                                output logic co);
    int ia, ib, r;
    ia = oa[W-1] ? int'(oa) - (1 << W) : int'(oa);
    ib = ob[W-1] ? int'(ob) - (1 << W) : int'(ob);
    r  = os ? ia - ib : ia + ib;
    ov = (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
    s  = W'(r);
    if (sat && ov) s = (r > 0) ? W'((1 << (W-1)) - 1) : W'(1 << (W-1));
    co = os ? (int'(oa) >= int'(ob)) : ((int'(oa) + int'(ob)) >= (1 << W));
  endfunction

  // Called #1 after a rising edge with the DUTs idle; returns cycles until instance 0 shows out_valid.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_b, input logic ts,
                        input logic tm, input logic tc, output int lat);
    a = ta; b = tb_b; sub = ts; acc_mode = tm; clr_acc = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; clr_acc = 1'b0;
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (out_valid_v[0]) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      n_chk++;
      if ({out_valid_v[i], ovf_v[i], co_v[i], sum_v[i], acc_v[i]} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: got vld=%b ovf=%b co=%b sum=%h acc=%h, need all 0",
                 i, out_valid_v[i], ovf_v[i], co_v[i], sum_v[i], acc_v[i]);
      end
      n_chk++;
      if (in_ready_v[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_in_ready[%0d]: got %b need 1", i, in_ready_v[i]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_latency();
    int lat;
    run_op(10'd100, 10'd27, 1'b0, 1'b0, 1'b0, lat);
    n_chk++;
    if (lat !== 5) begin n_fail++; $display("FAIL add_latency: got %0d cycles need 5", lat); end
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if ({sum_v[i], ovf_v[i], co_v[i]} !== {10'd127, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL add_result[%0d]: got sum=%h ovf=%b co=%b need 07f 0 0", i, sum_v[i], ovf_v[i], co_v[i]);
      end
    end
    release_out();
  endtask

  task automatic test_sub_negative();
    int lat;
    run_op(10'd5, 10'd12, 1'b1, 1'b0, 1'b0, lat);
    n_chk++;
    if ({sum_v[0], ovf_v[0], co_v[0]} !== {10'h3F9, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL sub_neg: got sum=%h ovf=%b co=%b need 3f9 0 0", sum_v[0], ovf_v[0], co_v[0]);
    end
    release_out();
  endtask

  task automatic test_overflow();
    int lat;
    run_op(10'd511, 10'd1, 1'b0, 1'b0, 1'b0, lat);
    n_chk++;
    if ({sum_v[0], ovf_v[0], co_v[0]} !== {10'h200, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL pos_ovf_wrap: got sum=%h ovf=%b co=%b need 200 1 0", sum_v[0], ovf_v[0], co_v[0]);
    end
    n_chk++;
    if ({sum_v[1], ovf_v[1]} !== {10'h1FF, 1'b1}) begin
      n_fail++;
      $display("FAIL pos_ovf_sat: got sum=%h ovf=%b need 1ff 1", sum_v[1], ovf_v[1]);
    end
    release_out();
    run_op(10'h200, 10'd1, 1'b1, 1'b0, 1'b0, lat);
    n_chk++;
    if ({sum_v[0], ovf_v[0], co_v[0]} !== {10'h1FF, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL neg_ovf_wrap: got sum=%h ovf=%b co=%b need 1ff 1 1", sum_v[0], ovf_v[0], co_v[0]);
    end
    n_chk++;
    if ({sum_v[1], ovf_v[1]} !== {10'h200, 1'b1}) begin
      n_fail++;
      $display("FAIL neg_ovf_sat: got sum=%h ovf=%b need 200 1", sum_v[1], ovf_v[1]);
    end
    release_out();
  endtask

  task automatic test_accumulate();
    int lat;
    clr_acc = 1'b1;
    @(posedge clk); #1;
    clr_acc = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (acc_v[i] !== '0) begin n_fail++; $display("FAIL acc_clear[%0d]: got %h need 000", i, acc_v[i]); end
    end
    for (int step = 1; step <= 3; step++) begin
      run_op(10'd0, 10'd3, 1'b0, 1'b1, 1'b0, lat);
      n_chk++;
      if (sum_v[0] !== W'(3 * step)) begin
        n_fail++;
        $display("FAIL acc_sum step %0d: got %h need %h", step, sum_v[0], W'(3 * step));
      end
      if (step == 3) begin
        for (int j = 0; j < 4; j++) begin
          n_chk++;
          if ({out_valid_v[0], in_ready_v[0], sum_v[0], acc_v[0]} !== {1'b1, 1'b0, 10'd9, 10'd6}) begin
            n_fail++;
            $display("FAIL hold cycle %0d: got vld=%b rdy=%b sum=%h acc=%h need 1 0 009 006",
                     j, out_valid_v[0], in_ready_v[0], sum_v[0], acc_v[0]);
          end
          @(posedge clk); #1;
        end
      end
      release_out();
      n_chk++;
      if ({acc_v[0], in_ready_v[0]} !== {W'(3 * step), 1'b1}) begin
        n_fail++;
        $display("FAIL acc_value step %0d: got acc=%h rdy=%b need %h 1", step, acc_v[0], in_ready_v[0], W'(3 * step));
      end
    end
  endtask

  task automatic test_reset_midrun();
    logic seen;
    a = 10'd100; b = 10'd27; sub = 1'b0; acc_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({out_valid_v[0], acc_v[0], sum_v[0]} !== {1'b0, 10'd0, 10'd0}) begin
      n_fail++;
      $display("FAIL midrun_reset: got vld=%b acc=%h sum=%h need 0 000 000", out_valid_v[0], acc_v[0], sum_v[0]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (in_ready_v[0] !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b need 1", in_ready_v[0]); end
    seen = 1'b0;
    repeat (12) begin
      seen = seen | (|out_valid_v);
      @(posedge clk); #1;
    end
    n_chk++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL discarded_op: got out_valid %b need 0", seen); end
  endtask

  task automatic test_random();
    logic [W-1:0] acc_m [NI];
    logic [W-1:0] exp_s [NI];
    logic [W-1:0] ra, rb, opa, es;
    logic         rs, rm, rc, eo, ec;
    for (int i = 0; i < NI; i++) acc_m[i] = '0;
    for (int op = 0; op < NOPS; op++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 7) == 0) ra = ($urandom_range(0, 1) == 0) ? 10'h1FF : 10'h200;
      rs = 1'($urandom);
      rm = ($urandom_range(0, 3) == 0);
      rc = ($urandom_range(0, 7) == 0);
      n_chk++;
      if (in_ready_v !== '1) begin n_fail++; $display("FAIL rand_ready op %0d: got %b need 11111", op, in_ready_v); end
      a = ra; b = rb; sub = rs; acc_mode = rm; clr_acc = rc; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; clr_acc = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        opa = rm ? (rc ? '0 : acc_m[i]) : ra;
        model(opa, rb, rs, sat_of(i), es, eo, ec);
        exp_s[i] = es;
        n_chk++;
        if ({out_valid_v[i], sum_v[i], ovf_v[i], co_v[i]} !== {1'b1, es, eo, ec}) begin
          n_fail++;
          $display("FAIL rand_result[%0d] op %0d (%h %s %h): got vld=%b sum=%h ovf=%b co=%b need 1 %h %b %b",
                   i, op, opa, rs ? "-" : "+", rb, out_valid_v[i], sum_v[i], ovf_v[i], co_v[i], es, eo, ec);
        end
      end
      release_out();
      for (int i = 0; i < NI; i++) begin
        acc_m[i] = exp_s[i];
        n_chk++;
        if (acc_v[i] !== acc_m[i]) begin
          n_fail++;
          $display("FAIL rand_acc[%0d] op %0d: got %h need %h", i, op, acc_v[i], acc_m[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_sub_negative();
    test_overflow();
    test_accumulate();
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
